// File: rtl/predictor_update_scheduler.sv
// Two-requester round-robin intake feeding an in-order branch-predictor update FIFO.
// Define PRED_UPDATE_BYPASS_EN to issue an accepted request in the same cycle when the FIFO is empty.
module predictor_update_scheduler #(
    parameter int INDEX_LEN = 10,
    parameter int DEPTH     = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   is_stalling,
    input  logic                   flush,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [2*INDEX_LEN-1:0] req_index,
    input  logic [1:0]             req_taken,
    input  logic [1:0]             req_rollback,
    output logic                   upd_enable,
    output logic [INDEX_LEN-1:0]   upd_index,
    output logic                   upd_taken,
    output logic                   upd_rollback,
    output logic [$clog2(DEPTH):0] count,
    output logic [15:0]            rollback_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = INDEX_LEN + 2;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [EW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [15:0]   r_rb_count;
    logic          r_prio;

    logic          w_grant;
    logic          w_accept;
    logic          w_push;
    logic          w_pop;
    logic          w_bypass;
    logic [EW-1:0] w_req_entry;
    logic [EW-1:0] w_issue;

    // r_prio names the requester that wins when both are valid.
    assign w_grant  = (req_valid == 2'b11) ? r_prio : req_valid[1];
    assign w_accept = reset && (req_valid != 2'b00) && !flush && (r_count != FULL_COUNT);
    assign w_pop    = (r_count != '0) && !is_stalling && !flush;

    assign w_req_entry = w_grant ? {req_index[2*INDEX_LEN-1:INDEX_LEN], req_taken[1], req_rollback[1]}
                                 : {req_index[INDEX_LEN-1:0],           req_taken[0], req_rollback[0]};

`ifdef PRED_UPDATE_BYPASS_EN
    assign w_bypass = w_accept && (r_count == '0) && !is_stalling;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_push     = w_accept && !w_bypass;
    assign upd_enable = w_pop || w_bypass;

    always_comb begin
        // NOTE: defaults come first so no path through this block can infer a latch.
        req_ready = 2'b00;
        w_issue   = r_mem[r_rd_ptr];
        if (w_accept)
            req_ready = w_grant ? 2'b10 : 2'b01;
        if (w_bypass)
            w_issue = w_req_entry;
    end

    assign {upd_index, upd_taken, upd_rollback} = w_issue;
    assign count          = r_count;
    assign rollback_count = r_rb_count;

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_prio     <= 1'b0;
            r_rb_count <= '0;
        end else begin
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push)
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop)
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
            if (w_accept)
                r_prio <= ~w_grant;
            if (upd_enable && upd_rollback && (r_rb_count != 16'hFFFF))
                r_rb_count <= r_rb_count + 16'd1;
        end
    end

    // NOTE: storage is not reset; the pointers and count alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= w_req_entry;
    end

endmodule
